alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one instance of the combinational 8-bit ALU between NUM_REQ requesters.
- Uses a round-robin grant, a valid/ready request handshake per requester and a registered, backpressurable response channel tagged with the requester id.
- Sits between client blocks (sequencers, address units) and the ALU datapath.
- Also defines the ALU's undefined cases: divide/modulo by zero and unused opcodes.

Parameters:
- BITS, 8, operand/result width; taken from the shared package.
- NUM_REQ, 2, number of requesters (>=2).
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept, at most one bit set.
- req_a  input  NUM_REQ*BITS  operand a, requester i at bits [i*BITS +: BITS].
- req_b  input  NUM_REQ*BITS  operand b, same packing as req_a.
- req_op  input  NUM_REQ*3  opcode, requester i at bits [i*3 +: 3].
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_result  output  BITS  operation result.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_err  output  1  div/mod by zero or undefined opcode.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values (applied asynchronously): state=IDLE, rsp_valid=0, rsp_result=0, rsp_id=0, rsp_err=0, operand/op/id registers=0, last_grant=NUM_REQ-1 (requester 0 wins first). req_ready=0 and busy=0 follow from IDLE.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant search starts at (last_grant+1) mod NUM_REQ and wraps; the first index with req_valid=1 wins.
  - req_ready[g]=1 for the winner only, combinationally, in the same cycle.
  - On the handshake: latch a, b, op and id=g; last_grant<=g; go to EXEC.
  - No valid request: stay in IDLE with req_ready=0.
- EXEC:
  - The ALU evaluates the latched operands.
  - rsp_result, rsp_err and rsp_id are registered; go to RESP.
- RESP:
  - rsp_valid=1; result, id and err held stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid<=0, go to IDLE.
  - req_ready=0 in both EXEC and RESP.
- Latency: request accepted at edge T; rsp_valid high from cycle T+2. Minimum request spacing is 3 cycles. No new accept in the cycle the response handshakes.
- Requester rule: once req_valid is high, the requester holds valid, a, b and op stable until req_ready. The bench asserts this rule.
- Arithmetic (all modulo 2^BITS):
  - Opcodes: ADD=0, SUB=1, MUL=2, DIV=3, MOD=4, SHR=5, SHL=6.
  - SUB wraps; MUL keeps the low BITS bits.
  - DIV/MOD are unsigned.
  - DIV or MOD with b==0: result=0, err=1.
  - SHR/SHL are logical; any shift amount >= BITS gives 0, err=0.
  - Opcode 7: result=0, err=1.
- Reset mid-operation: the in-flight request is discarded, no response is produced, and arbitration restarts at requester 0.
- A requester that drops req_valid while not granted loses no state; fairness is decided only at grant time.

Decomposition:
- Package alu_pkg holds:
  - BITS.
  - The OperationType enum (OP_ADD..OP_SHL, 3-bit base type).
  - Constant OP_W=3.
- Sub-module: the existing alu, instantiated once on the latched operands.
- The b==0 and opcode-7 overrides are applied in alu_arbiter around the instance, not inside alu.
- A round-robin priority picker may be written as a function; it is not a separate module.

Test Plan:
- ADD on requester 0: a=200, b=100 accepted at T -> rsp_valid at T+2, rsp_result=44, rsp_id=0, rsp_err=0, busy high at T+1 and T+2.
- Both requesters valid from reset release and held after each accept (req0 repeats SUB 5-7, req1 repeats MUL 16*17), rsp_ready=1:
  - grant order 0,1,0,1;
  - results 8'hFE and 16 alternating;
  - rsp_id alternates 0,1.
- Divide cases on requester 1:
  - DIV 200/7 -> 28, err 0; MOD 200/7 -> 4, err 0;
  - DIV 7/0 -> 0, err 1; MOD 7/0 -> 0, err 1;
  - op=7 -> 0, err 1; SHL 1<<9 -> 0, err 0; SHR 8'h80>>7 -> 1.
- Backpressure: rsp_ready=0 for 5 cycles while req0 and req1 are valid:
  - rsp_valid, rsp_result and rsp_id stay stable;
  - req_ready==0 throughout;
  - when rsp_ready rises, the handshake occurs, and the next grant (to req1) comes one cycle later.
- Reset while in EXEC with req1 in flight:
  - rsp_valid, busy and req_ready go to 0 without waiting for a clock edge;
  - no response for req1 appears;
  - after release with both valid, req0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its requester arbiter.
package alu_pkg;

    localparam int BITS = 8;
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4,
        OP_SHR = 3'd5,
        OP_SHL = 3'd6
    } OperationType;

endpackage

// File: rtl/alu.sv
// Combinational unsigned ALU. Divide-by-zero and opcode 7 results are don't-care
// here; the arbiter overrides them.
module alu
    import alu_pkg::*;
(
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic [OP_W-1:0] op,
    output logic [BITS-1:0] result
);

    always_comb begin
        // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_DIV:  result = a / b;
            OP_MOD:  result = a % b;
            // Logical shifts naturally give 0 once the amount reaches BITS.
            OP_SHR:  result = a >> b;
            OP_SHL:  result = a << b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, with a
// registered, backpressurable response tagged by requester id.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*BITS-1:0] req_a,
    input  logic [NUM_REQ*BITS-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0] req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [BITS-1:0]         rsp_result,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_err,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [BITS-1:0] a_q, b_q;
    logic [OP_W-1:0] op_q;
    logic [ID_W-1:0] id_q, last_grant;
    logic [ID_W-1:0] grant;
    logic            grant_any;
    logic [BITS-1:0] alu_result;
    logic            undef_err;

    // First valid index after the previous winner, wrapping.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] win;
        logic [ID_W-1:0] cand;
        logic            found;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last) + k) % NUM_REQ);
            if (!found && valid[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign grant     = rr_pick(req_valid, last_grant);
    assign grant_any = |req_valid;
    assign busy      = (state != IDLE);

    // Gated by rst so no requester sees an accept while reset is held.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_any && !rst)
            req_ready[grant] = 1'b1;
    end

    alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
    );

    assign undef_err = ((op_q == OP_DIV || op_q == OP_MOD) && b_q == '0)
                     || (op_q == OP_W'(7));

    // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            id_q       <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_q        <= req_a[grant*BITS +: BITS];
                        b_q        <= req_b[grant*BITS +: BITS];
                        op_q       <= req_op[grant*OP_W +: OP_W];
                        id_q       <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= undef_err ? '0 : alu_result;
                    rsp_err    <= undef_err;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
